// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the byte-serial RAM arbiter: access sizes, FSM states,
// port IDs and the zero word.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_WORD3 = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  typedef enum logic {
    PORT_IF  = 1'b0,
    PORT_MEM = 1'b1
  } port_e;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // Byte count of an access; encoding 3 is treated as a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the arbiter (slave) and the fetch/MEM requesters plus the
// byte-wide RAM (master side, driven by the surrounding CPU or a bench).
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [31:0]       if_inst_o;
  logic              if_done_o;

  logic              mem_req_i;
  logic              mem_we_i;
  logic [1:0]        mem_size_i;
  logic              mem_sext_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [31:0]       mem_wdata_i;
  logic [31:0]       mem_rdata_o;
  logic              mem_done_o;

  logic [7:0]        ram_din_i;
  logic [ADDR_W-1:0] ram_a_o;
  logic              ram_wr_o;
  logic [7:0]        ram_dout_o;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_inst_o, if_done_o,
    input  mem_req_i, mem_we_i, mem_size_i, mem_sext_i, mem_addr_i, mem_wdata_i,
    output mem_rdata_o, mem_done_o,
    input  ram_din_i,
    output ram_a_o, ram_wr_o, ram_dout_o
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_inst_o, if_done_o,
    output mem_req_i, mem_we_i, mem_size_i, mem_sext_i, mem_addr_i, mem_wdata_i,
    input  mem_rdata_o, mem_done_o,
    output ram_din_i,
    input  ram_a_o, ram_wr_o, ram_dout_o
  );

endinterface

// File: rtl/mem_load_ext.sv
// Size/sign extension of an assembled little-endian word into a load result.
module mem_load_ext
  import mem_arbiter_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        sext_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    byte_s = word_i[7:0];
    half_s = word_i[15:0];
    data_o = word_i;
    case (size_i)
      SZ_BYTE: data_o = sext_i ? 32'(byte_s) : {24'b0, word_i[7:0]};
      SZ_HALF: data_o = sext_i ? 32'(half_s) : {16'b0, word_i[15:0]};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Byte-serial RAM arbiter between instruction fetch and MEM data accesses.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is MEM-first priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int RAM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus,
  output logic          busy_o
);

  if (RAM_LAT != 1) begin : g_lat_check
    $error("mem_arbiter supports RAM_LAT == 1 only");
  end

  state_e            state_q;
  port_e             owner_q;
  logic [2:0]        step_q;
  logic              if_done_q, mem_done_q;
  logic [31:0]       if_inst_q, mem_rdata_q;
  logic [ADDR_W-1:0] ram_a_q;
  logic              ram_wr_q;
  logic [7:0]        ram_dout_q;

  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [2:0]        n_q;
  logic              sext_q;
  logic [31:0]       wdata_q;
  logic [31:0]       lanes_q, lanes_d;

  logic              if_vld, mem_vld, grant_mem, grant_any;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_we;
  logic [1:0]        lane_idx;
  logic [31:0]       mem_ext;

  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
    return w[8*idx +: 8];
  endfunction

  // A port whose done pulse is showing is masked so it can drop its request.
  assign if_vld    = bus.if_req_i  & ~if_done_q;
  assign mem_vld   = bus.mem_req_i & ~mem_done_q;
  assign grant_any = if_vld | mem_vld;

`ifdef MEM_ARB_RR_EN
  port_e last_q;
  assign grant_mem = mem_vld & (~if_vld | (last_q == PORT_IF));

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= PORT_IF;
    end else if (state_q == ST_IDLE && grant_any) begin
      last_q <= grant_mem ? PORT_MEM : PORT_IF;
    end
  end
`else
  assign grant_mem = mem_vld;
`endif

  always_comb begin
    req_addr = grant_mem ? bus.mem_addr_i : bus.if_addr_i;
    req_size = grant_mem ? bus.mem_size_i : SZ_WORD;
    req_we   = grant_mem & bus.mem_we_i;
  end

  // Byte returned this cycle was addressed two edges ago.
  always_comb begin
    lane_idx = 2'(step_q - 3'd2);
    lanes_d  = lanes_q;
    lanes_d[8*lane_idx +: 8] = bus.ram_din_i;
  end

  mem_load_ext u_load_ext (
    .size_i (size_q),
    .sext_i (sext_q),
    .word_i (lanes_d),
    .data_o (mem_ext)
  );

  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && grant_any) begin
      addr_q  <= req_addr;
      size_q  <= req_size;
      n_q     <= size_bytes(req_size);
      sext_q  <= bus.mem_sext_i;
      wdata_q <= bus.mem_wdata_i;
    end
    if (state_q == ST_READ && step_q >= 3'd2) begin
      lanes_q <= lanes_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= PORT_IF;
      step_q      <= 3'd0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_inst_q   <= ZERO_WORD;
      mem_rdata_q <= ZERO_WORD;
      ram_a_q     <= '0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= 8'h00;
    end else begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_any) begin
            owner_q <= grant_mem ? PORT_MEM : PORT_IF;
            step_q  <= 3'd1;
            ram_a_q <= req_addr;
            if (req_we) begin
              ram_wr_q   <= 1'b1;
              ram_dout_q <= bus.mem_wdata_i[7:0];
              state_q    <= ST_WRITE;
            end else begin
              state_q    <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (step_q < n_q) begin
            ram_a_q <= addr_q + ADDR_W'(step_q);
          end
          if (step_q == n_q + 3'd1) begin
            ram_a_q <= '0;
            state_q <= ST_IDLE;
            if (owner_q == PORT_MEM) begin
              mem_done_q  <= 1'b1;
              mem_rdata_q <= mem_ext;
            end else begin
              if_done_q   <= 1'b1;
              if_inst_q   <= lanes_d;
            end
          end else begin
            step_q <= step_q + 3'd1;
          end
        end
        ST_WRITE: begin
          if (step_q == n_q) begin
            ram_wr_q   <= 1'b0;
            ram_a_q    <= '0;
            ram_dout_q <= 8'h00;
            mem_done_q <= 1'b1;
            state_q    <= ST_IDLE;
          end else begin
            ram_a_q    <= addr_q + ADDR_W'(step_q);
            ram_dout_q <= get_byte(wdata_q, step_q[1:0]);
            step_q     <= step_q + 3'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.if_inst_o   = if_inst_q;
  assign bus.if_done_o   = if_done_q;
  assign bus.mem_rdata_o = mem_rdata_q;
  assign bus.mem_done_o  = mem_done_q;
  assign bus.ram_a_o     = ram_a_q;
  assign bus.ram_wr_o    = ram_wr_q;
  assign bus.ram_dout_o  = ram_dout_q;
  assign busy_o          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single transactions plus
// arbitration and mid-store reset sequences against a 1-cycle-latency RAM model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  mem_arbiter_if #(.ADDR_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .RAM_LAT(1)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .busy_o (busy)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [logic [31:0]];

  always @(posedge clk) begin
    bus.ram_din_i <= ram[bus.ram_a_o];
    if (bus.ram_wr_o) ram[bus.ram_a_o] = bus.ram_dout_o;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_if;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs [14];

  // Entered and left #1 after a rising edge with the arbiter idle.
  task automatic run_txn(input int idx, input vec_t v);
    int   n;
    int   cyc;
    logic seen;
    logic done;
    n    = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
    cyc  = 0;
    seen = 1'b0;
    if (v.is_if) begin
      bus.if_addr_i = v.addr;
      bus.if_req_i  = 1'b1;
    end else begin
      bus.mem_we_i    = v.we;
      bus.mem_size_i  = v.size;
      bus.mem_sext_i  = v.sext;
      bus.mem_addr_i  = v.addr;
      bus.mem_wdata_i = v.wdata;
      bus.mem_req_i   = 1'b1;
    end
    while (!seen && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) chk($sformatf("v%0d busy", idx), {31'b0, busy}, 32'd1);
      if (cyc >= 1 && cyc <= n) begin
        chk($sformatf("v%0d ram_a c%0d", idx, cyc), bus.ram_a_o, v.addr + 32'(cyc - 1));
        if (v.we) begin
          chk($sformatf("v%0d ram_wr c%0d", idx, cyc), {31'b0, bus.ram_wr_o}, 32'd1);
          chk($sformatf("v%0d ram_dout c%0d", idx, cyc), {24'b0, bus.ram_dout_o},
              {24'b0, v.wdata[8*(cyc-1) +: 8]});
        end
      end
      done = v.is_if ? bus.if_done_o : bus.mem_done_o;
      if (done) begin
        seen = 1'b1;
        bus.if_req_i  = 1'b0;
        bus.mem_req_i = 1'b0;
      end
    end
    chk($sformatf("v%0d latency", idx), 32'(cyc), 32'(v.exp_lat));
    chk($sformatf("v%0d data", idx), v.is_if ? bus.if_inst_o : bus.mem_rdata_o, v.exp_data);
    chk($sformatf("v%0d ram_a end", idx), bus.ram_a_o, 32'h0);
    chk($sformatf("v%0d ram_wr end", idx), {31'b0, bus.ram_wr_o}, 32'd0);
    @(posedge clk); #1;
    chk($sformatf("v%0d done pulse", idx), {30'b0, bus.if_done_o, bus.mem_done_o}, 32'd0);
    chk($sformatf("v%0d idle", idx), {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int          c, if_at, mem_at;
    logic [31:0] ra [0:31];
    logic [31:0] first_a, second_a;
    int          first_done, second_done;
    vec_t        v;

    rst             = 1'b1;
    bus.if_req_i    = 1'b0;
    bus.if_addr_i   = 32'h0;
    bus.mem_req_i   = 1'b0;
    bus.mem_we_i    = 1'b0;
    bus.mem_size_i  = 2'd0;
    bus.mem_sext_i  = 1'b0;
    bus.mem_addr_i  = 32'h0;
    bus.mem_wdata_i = 32'h0;

    ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'hA0; ram[32'h103] = 8'h00;
    ram[32'h20]  = 8'h80;
    ram[32'h31]  = 8'h34; ram[32'h32]  = 8'h92;
    ram[32'h40]  = 8'h11; ram[32'h41]  = 8'h22; ram[32'h42]  = 8'h33; ram[32'h43]  = 8'h44;
    ram[32'h60]  = 8'hEE; ram[32'h61]  = 8'hEE; ram[32'h62]  = 8'hEE; ram[32'h63]  = 8'hEE;

    //          is_if we    size  sext  addr          wdata         exp_data      lat
    vecs[0]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h00000100, 32'h0,        32'h00A00513, 6};
    vecs[1]  = '{1'b0, 1'b0, 2'd0, 1'b1, 32'h00000020, 32'h0,        32'hFFFFFF80, 3};
    vecs[2]  = '{1'b0, 1'b0, 2'd0, 1'b0, 32'h00000020, 32'h0,        32'h00000080, 3};
    vecs[3]  = '{1'b0, 1'b0, 2'd1, 1'b1, 32'h00000031, 32'h0,        32'hFFFF9234, 4};
    vecs[4]  = '{1'b0, 1'b0, 2'd1, 1'b0, 32'h00000031, 32'h0,        32'h00009234, 4};
    vecs[5]  = '{1'b0, 1'b0, 2'd2, 1'b1, 32'h00000040, 32'h0,        32'h44332211, 6};
    vecs[6]  = '{1'b0, 1'b0, 2'd3, 1'b1, 32'h00000040, 32'h0,        32'h44332211, 6};
    vecs[7]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h0001FFFE, 32'hDEADBEEF, 32'h44332211, 5};
    vecs[8]  = '{1'b0, 1'b1, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h0000A5C3, 32'h44332211, 3};
    vecs[9]  = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h00000050, 32'hFFFFFF77, 32'h44332211, 2};
    vecs[10] = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h0001FFFE, 32'h0,        32'hDEADBEEF, 6};
    vecs[11] = '{1'b0, 1'b0, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h0,        32'h0000A5C3, 4};
    vecs[12] = '{1'b0, 1'b0, 2'd0, 1'b1, 32'h00000050, 32'h0,        32'h00000077, 3};
    vecs[13] = '{1'b0, 1'b0, 2'd1, 1'b1, 32'hFFFFFFFF, 32'h0,        32'hFFFFA5C3, 4};

    repeat (3) @(posedge clk);
    #1;
    chk("reset if_inst",   bus.if_inst_o,   32'h0);
    chk("reset mem_rdata", bus.mem_rdata_o, 32'h0);
    chk("reset ram_a",     bus.ram_a_o,     32'h0);
    chk("reset ram_wr",    {31'b0, bus.ram_wr_o}, 32'd0);
    chk("reset ram_dout",  {24'b0, bus.ram_dout_o}, 32'd0);
    chk("reset dones",     {30'b0, bus.if_done_o, bus.mem_done_o}, 32'd0);
    chk("reset busy",      {31'b0, busy}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) run_txn(i, vecs[i]);
    chk("if_inst held", bus.if_inst_o, 32'h00A00513);

    // Simultaneous requests; the last grant was MEM.
    bus.if_addr_i   = 32'h100;
    bus.mem_we_i    = 1'b0;
    bus.mem_size_i  = 2'd0;
    bus.mem_sext_i  = 1'b1;
    bus.mem_addr_i  = 32'h20;
    bus.if_req_i    = 1'b1;
    bus.mem_req_i   = 1'b1;
    c = 0; if_at = 0; mem_at = 0;
    for (int k = 0; k < 32; k++) ra[k] = 32'h0;
    while ((if_at == 0 || mem_at == 0) && c < 30) begin
      @(posedge clk); #1;
      c++;
      ra[c] = bus.ram_a_o;
      if (bus.if_done_o && if_at == 0) begin
        if_at = c;
        bus.if_req_i = 1'b0;
      end
      if (bus.mem_done_o && mem_at == 0) begin
        mem_at = c;
        bus.mem_req_i = 1'b0;
      end
    end
`ifdef MEM_ARB_RR_EN
    first_a = 32'h100; second_a = 32'h20; first_done = 6; second_done = 9;
    chk("arb first done",  32'(if_at),  32'(first_done));
    chk("arb second done", 32'(mem_at), 32'(second_done));
`else
    first_a = 32'h20; second_a = 32'h100; first_done = 3; second_done = 9;
    chk("arb first done",  32'(mem_at), 32'(first_done));
    chk("arb second done", 32'(if_at),  32'(second_done));
`endif
    chk("arb first addr",  ra[1], first_a);
    chk("arb second addr", ra[first_done + 1], second_a);
    chk("arb mem data", bus.mem_rdata_o, 32'hFFFFFF80);
    chk("arb if data",  bus.if_inst_o,   32'h00A00513);
    @(posedge clk); #1;

    // Reset while the second byte of a word store is on the bus.
    bus.mem_we_i    = 1'b1;
    bus.mem_size_i  = 2'd2;
    bus.mem_sext_i  = 1'b0;
    bus.mem_addr_i  = 32'h60;
    bus.mem_wdata_i = 32'h11223344;
    bus.mem_req_i   = 1'b1;
    @(posedge clk); #1;
    chk("rst sw byte0 wr", {31'b0, bus.ram_wr_o}, 32'd1);
    @(posedge clk); #1;
    chk("rst sw byte1 addr", bus.ram_a_o, 32'h61);
    rst = 1'b1;
    bus.mem_req_i = 1'b0;
    @(posedge clk); #1;
    chk("rst ram_wr",    {31'b0, bus.ram_wr_o}, 32'd0);
    chk("rst busy",      {31'b0, busy}, 32'd0);
    chk("rst mem_done",  {31'b0, bus.mem_done_o}, 32'd0);
    chk("rst mem_rdata", bus.mem_rdata_o, 32'h0);
    chk("rst if_inst",   bus.if_inst_o, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst no done", {31'b0, bus.mem_done_o}, 32'd0);
    v = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h00000060, 32'h0, 32'hEEEE3344, 6};
    run_txn(99, v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
